// File: rtl/trig_sched_pkg.sv
// trig_pkg: shared types and constants for the trig request scheduler.
//   trig_sched_state_t : scheduler FSM states
//   ANGLE_MAX          : first illegal angle (tenths of a degree)
//   ANGLE_W / VAL_W    : default angle and trig value widths
package trig_pkg;

  localparam int ANGLE_W   = 12;
  localparam int VAL_W     = 10;
  localparam int ANGLE_MAX = 3600;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIN  = 2'd1,
    COS  = 2'd2,
    DONE = 2'd3
  } trig_sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request lines
//   upd      : pointer update enable (advance on a taken grant)
//   gnt[1:0] : one-hot grant (combinational)
// The pointer holds the index granted last; it resets to 1 so requester 0
// wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic ptr;

  // A single requester is granted regardless of the pointer; on a tie the
  // requester not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)                ptr <= 1'b1;
    else if (upd && |gnt)   ptr <= gnt[1];
  end

endmodule

// File: rtl/trig_sched.sv
// trig_sched: time-shares one trig LUT between two angle clients.
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/degree/ready       : client N angle request (valid/ready)
//   trig_degree, trig_iscos       : drive the shared trig unit
//   trig_value                    : trig unit output, LAT clocks after inputs
//   res_valid/ready               : result handshake
//   res_id, res_sin, res_cos      : requester index and encoded values
//   res_err                       : requested angle was out of range
// Each accepted request does a sine lookup then a cosine lookup, each held
// for LAT+1 cycles, and returns both values together.
module trig_sched
  import trig_pkg::trig_sched_state_t, trig_pkg::ANGLE_MAX,
         trig_pkg::IDLE, trig_pkg::SIN, trig_pkg::COS, trig_pkg::DONE;
#(
  parameter int LAT     = 1,
  parameter int ANGLE_W = trig_pkg::ANGLE_W,
  parameter int VAL_W   = trig_pkg::VAL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [ANGLE_W-1:0] req0_degree,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ANGLE_W-1:0] req1_degree,
  output logic               req1_ready,
  output logic [ANGLE_W-1:0] trig_degree,
  output logic               trig_iscos,
  input  logic [VAL_W-1:0]   trig_value,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [VAL_W-1:0]   res_sin,
  output logic [VAL_W-1:0]   res_cos,
  output logic               res_err
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  trig_sched_state_t  state;
  logic [CNT_W-1:0]   cnt;
  logic               idle;
  logic [1:0]         arb_req;
  logic [1:0]         gnt;
  logic               accept;
  logic [ANGLE_W-1:0] sel_deg;
  logic               sel_oor;
  logic               cnt_last;

  assign idle = (state == IDLE);

  // Requests are only visible to the arbiter while idle, so the grant (and
  // hence ready) is zero whenever the shared unit is busy.
  assign arb_req = {req1_valid, req0_valid} & {2{idle}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .upd (idle),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;
  assign sel_deg    = gnt[1] ? req1_degree : req0_degree;
  assign sel_oor    = 32'(sel_deg) >= ANGLE_MAX;
  assign cnt_last   = (cnt == CNT_W'(LAT));

  // trig_degree doubles as the latched angle; it is only written for legal
  // angles so an out-of-range request never disturbs the trig unit inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      trig_degree <= '0;
      trig_iscos  <= 1'b0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_sin     <= '0;
      res_cos     <= '0;
      res_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            res_id <= gnt[1];
            cnt    <= '0;
            if (sel_oor) begin
              res_err   <= 1'b1;
              res_sin   <= '0;
              res_cos   <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              res_err     <= 1'b0;
              trig_degree <= sel_deg;
              trig_iscos  <= 1'b0;
              state       <= SIN;
            end
          end
        end
        SIN: begin
          if (cnt_last) begin
            res_sin    <= trig_value;
            cnt        <= '0;
            trig_iscos <= 1'b1;
            state      <= COS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COS: begin
          // iscos drops on the same edge the cosine is sampled, so it was
          // stable through the whole sample cycle.
          if (cnt_last) begin
            res_cos    <= trig_value;
            cnt        <= '0;
            trig_iscos <= 1'b0;
            res_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_sched.sv
// tb_trig_sched: directed scenarios plus a randomized two-client run for
// trig_sched, checked against a cycle-count/arbitration reference model and a
// real-valued sine/cosine model of the shared trig unit.
module tb_trig_sched;

  localparam int LAT = 1;
  localparam int AW  = 12;
  localparam int VW  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_degree, req1_degree;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] trig_degree;
  logic          trig_iscos;
  logic [VW-1:0] trig_value = '0;
  logic          res_valid, res_ready, res_id, res_err;
  logic [VW-1:0] res_sin, res_cos;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trig_sched #(.LAT(LAT), .ANGLE_W(AW), .VAL_W(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_degree (req0_degree),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_degree (req1_degree),
    .req1_ready  (req1_ready),
    .trig_degree (trig_degree),
    .trig_iscos  (trig_iscos),
    .trig_value  (trig_value),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_sin     (res_sin),
    .res_cos     (res_cos),
    .res_err     (res_err)
  );

  // Encoded trig value: sign bit + 9-bit magnitude scaled to 511.
  function automatic logic [VW-1:0] trig_ref(input logic [AW-1:0] d, input logic c);
    real a, s;
    int  m;
    a = real'(d) * 3.141592653589793 / 1800.0;
    s = c ? $cos(a) : $sin(a);
    m = int'((s < 0.0 ? -s : s) * 511.0);
    return {1'(s < -1.0e-9), 9'(m)};
  endfunction

  // Shared trig unit: registered lookup, LAT=1.
  always @(posedge clk) trig_value <= trig_ref(trig_degree, trig_iscos);

  task automatic idle_in();
    req0_valid = 1'b0; req0_degree = '0;
    req1_valid = 1'b0; req1_degree = '0;
    res_ready  = 1'b1;
  endtask

  // Wait (bounded) at negedges for res_valid, starting with the current one.
  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // One request from client c; returns cycles from accept to res_valid
  // (-1 on timeout) and the trig inputs seen in the first cycle after accept.
  task automatic xact(input int c, input logic [AW-1:0] d, output int lat,
                      output logic [AW-1:0] tdeg, output logic tcos);
    bit got;
    lat = -1; tdeg = '0; tcos = 1'b0; got = 1'b0;
    @(negedge clk);
    if (c == 0) begin req0_valid = 1'b1; req0_degree = d; end
    else        begin req1_valid = 1'b1; req1_degree = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = (c == 0) ? req0_ready : req1_ready;
      if (!got) @(negedge clk);
    end
    if (!got) begin idle_in(); return; end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tdeg = trig_degree; tcos = trig_iscos;
    for (int k = 1; k <= 40; k++) begin
      if (res_valid === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    repeat (3) @(negedge clk);
    checks++;
    if ({trig_degree, trig_iscos, res_valid, res_id, res_sin, res_cos, res_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got deg=%h cos=%b v=%b id=%b s=%h c=%h e=%b want all zero",
               trig_degree, trig_iscos, res_valid, res_id, res_sin, res_cos, res_err);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_degree = 12'd300; res_ready = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_grant: got %b want 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if ({trig_degree, trig_iscos, res_valid} !== {12'd300, 1'(k >= 3), 1'b0}) begin
        errors++;
        $display("FAIL single_cycle%0d: got deg=%0d cos=%b v=%b want deg=300 cos=%b v=0",
                 k, trig_degree, trig_iscos, res_valid, k >= 3);
      end
    end
    @(negedge clk);
    checks++;
    if ({res_valid, res_id, res_sin, res_cos, res_err} !==
        {1'b1, 1'b0, trig_ref(12'd300, 1'b0), trig_ref(12'd300, 1'b1), 1'b0}) begin
      errors++;
      $display("FAIL single_result: got v=%b id=%b s=%h c=%h e=%b want v=1 id=0 s=%h c=%h e=0",
               res_valid, res_id, res_sin, res_cos, res_err,
               trig_ref(12'd300, 1'b0), trig_ref(12'd300, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got res_valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_boundaries();
    int            angs[6] = '{0, 899, 900, 1800, 2700, 3599};
    int            lat;
    logic [AW-1:0] d, tdeg;
    logic          tcos;
    for (int i = 0; i < 6; i++) begin
      d = AW'(angs[i]);
      xact(i % 2, d, lat, tdeg, tcos);
      checks++;
      if (lat != 2 * (LAT + 1) + 1) begin
        errors++;
        $display("FAIL bound_latency: angle %0d got %0d want %0d", d, lat, 2 * (LAT + 1) + 1);
      end
      checks++;
      if ({tdeg, tcos} !== {d, 1'b0}) begin
        errors++;
        $display("FAIL bound_trig_in: got deg=%0d cos=%b want deg=%0d cos=0", tdeg, tcos, d);
      end
      checks++;
      if ({res_id, res_sin, res_cos, res_err} !==
          {1'(i % 2), trig_ref(d, 1'b0), trig_ref(d, 1'b1), 1'b0}) begin
        errors++;
        $display("FAIL bound_result: angle %0d got id=%b s=%h c=%h e=%b want id=%0d s=%h c=%h e=0",
                 d, res_id, res_sin, res_cos, res_err, i % 2, trig_ref(d, 1'b0), trig_ref(d, 1'b1));
      end
    end
  endtask

  task automatic test_out_of_range();
    int            lat;
    logic [AW-1:0] tdeg, prev, d;
    logic          tcos;
    prev = 12'd3599;  // last legal angle issued by the boundary scenario
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 12'd3600 : 12'd4095;
      xact(1, d, lat, tdeg, tcos);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL oor_latency: angle %0d got %0d want 1", d, lat);
      end
      checks++;
      if ({tdeg, tcos} !== {prev, 1'b0}) begin
        errors++;
        $display("FAIL oor_trig_in: got deg=%0d cos=%b want deg=%0d cos=0", tdeg, tcos, prev);
      end
      checks++;
      if ({res_id, res_sin, res_cos, res_err} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
        errors++;
        $display("FAIL oor_result: got id=%b s=%h c=%h e=%b want id=1 s=0 c=0 e=1",
                 res_id, res_sin, res_cos, res_err);
      end
    end
  endtask

  task automatic test_tie();
    bit ok;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_degree = 12'd100;
      req1_valid = 1'b1; req1_degree = 12'd2000;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
        errors++;
        $display("FAIL tie%0d_first: got %b want 01", t, {req1_ready, req0_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      wait_res(ok);
      checks++;
      if (!ok || {res_id, res_sin, res_cos, res_err} !==
                 {1'b0, trig_ref(12'd100, 1'b0), trig_ref(12'd100, 1'b1), 1'b0}) begin
        errors++;
        $display("FAIL tie%0d_res0: got ok=%b id=%b s=%h c=%h e=%b want id=0 s=%h c=%h e=0",
                 t, ok, res_id, res_sin, res_cos, res_err,
                 trig_ref(12'd100, 1'b0), trig_ref(12'd100, 1'b1));
      end
      @(negedge clk); #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
        errors++;
        $display("FAIL tie%0d_second: got %b want 10", t, {req1_ready, req0_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      wait_res(ok);
      checks++;
      if (!ok || {res_id, res_sin, res_cos, res_err} !==
                 {1'b1, trig_ref(12'd2000, 1'b0), trig_ref(12'd2000, 1'b1), 1'b0}) begin
        errors++;
        $display("FAIL tie%0d_res1: got ok=%b id=%b s=%h c=%h e=%b want id=1 s=%h c=%h e=0",
                 t, ok, res_id, res_sin, res_cos, res_err,
                 trig_ref(12'd2000, 1'b0), trig_ref(12'd2000, 1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    bit            ok;
    logic [VW-1:0] s1, c1;
    s1 = trig_ref(12'd1234, 1'b0);
    c1 = trig_ref(12'd1234, 1'b1);
    @(negedge clk);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_degree = 12'd1234;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_res(ok);
    req0_valid = 1'b1; req0_degree = 12'd500;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (!ok || {res_valid, req0_ready, res_id, res_sin, res_cos, res_err} !==
                 {1'b1, 1'b0, 1'b0, s1, c1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b rdy0=%b id=%b s=%h c=%h e=%b want v=1 rdy0=0 id=0 s=%h c=%h e=0",
                 i, res_valid, req0_ready, res_id, res_sin, res_cos, res_err, s1, c1);
      end
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({res_valid, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy0=%b want v=0 rdy0=1", res_valid, req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_res(ok);
    checks++;
    if (!ok || {res_id, res_sin, res_cos, res_err} !==
               {1'b0, trig_ref(12'd500, 1'b0), trig_ref(12'd500, 1'b1), 1'b0}) begin
      errors++;
      $display("FAIL bp_next: got ok=%b id=%b s=%h c=%h e=%b want id=0 s=%h c=%h e=0",
               ok, res_id, res_sin, res_cos, res_err, trig_ref(12'd500, 1'b0), trig_ref(12'd500, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    bit            seen;
    int            lat;
    logic [AW-1:0] tdeg;
    logic          tcos;
    @(negedge clk);
    req0_valid = 1'b1; req0_degree = 12'd700;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({trig_degree, trig_iscos} !== {12'd700, 1'b1}) begin
      errors++;
      $display("FAIL rm_in_cos: got deg=%0d cos=%b want deg=700 cos=1", trig_degree, trig_iscos);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({trig_degree, trig_iscos, res_valid, res_id, res_sin, res_cos, res_err,
         req1_ready, req0_ready} !== '0) begin
      errors++;
      $display("FAIL rm_outputs: got deg=%h cos=%b v=%b id=%b s=%h c=%h e=%b rdy=%b%b want all zero",
               trig_degree, trig_iscos, res_valid, res_id, res_sin, res_cos, res_err,
               req1_ready, req0_ready);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rm_no_result: got a result after reset want none");
    end
    xact(1, 12'd2500, lat, tdeg, tcos);
    checks++;
    if (lat != 2 * (LAT + 1) + 1 ||
        {res_id, res_sin, res_cos, res_err} !==
        {1'b1, trig_ref(12'd2500, 1'b0), trig_ref(12'd2500, 1'b1), 1'b0}) begin
      errors++;
      $display("FAIL rm_after: got lat=%0d id=%b s=%h c=%h e=%b want lat=%0d id=1 s=%h c=%h e=0",
               lat, res_id, res_sin, res_cos, res_err, 2 * (LAT + 1) + 1,
               trig_ref(12'd2500, 1'b0), trig_ref(12'd2500, 1'b1));
    end
  endtask

  // Random two-client traffic with random result backpressure. The model
  // knows only the rules: who should be granted, when the result is due
  // (2*(LAT+1)+1 cycles, or 1 for an illegal angle) and what it must contain.
  task automatic test_random();
    bit            mv[2];
    logic [AW-1:0] md[2];
    bit            busy;
    int            cnt, last, g;
    logic          eid, eerr;
    logic [VW-1:0] es, ec;
    logic [1:0]    er;
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy = 1'b0; cnt = 0; last = 1;
    eid = 1'b0; eerr = 1'b0; es = '0; ec = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!mv[n] && $urandom_range(0, 3) == 0) begin
          mv[n] = 1'b1;
          md[n] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(3600, 4095))
                                              : AW'($urandom_range(0, 3599));
        end
      end
      req0_valid = mv[0]; req0_degree = md[0];
      req1_valid = mv[1]; req1_degree = md[1];
      res_ready  = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (!busy) begin
        if (mv[0] && mv[1]) g = (last == 1) ? 0 : 1;
        else if (mv[0])     g = 0;
        else if (mv[1])     g = 1;
      end
      er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      checks++;
      if ({req1_ready, req0_ready} !== er) begin
        errors++;
        $display("FAIL rand_grant cyc %0d: got %b want %b", cyc, {req1_ready, req0_ready}, er);
      end
      checks++;
      if (res_valid !== (busy && cnt == 0)) begin
        errors++;
        $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, res_valid, busy && cnt == 0);
      end
      if (busy && cnt == 0) begin
        checks++;
        if ({res_id, res_sin, res_cos, res_err} !== {eid, es, ec, eerr}) begin
          errors++;
          $display("FAIL rand_result cyc %0d: got id=%b s=%h c=%h e=%b want id=%b s=%h c=%h e=%b",
                   cyc, res_id, res_sin, res_cos, res_err, eid, es, ec, eerr);
        end
      end
      if (busy) begin
        if (cnt == 0) begin
          if (res_ready) busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (g >= 0) begin
        busy = 1'b1;
        last = g;
        eid  = g[0];
        eerr = (md[g] >= 12'd3600);
        es   = eerr ? '0 : trig_ref(md[g], 1'b0);
        ec   = eerr ? '0 : trig_ref(md[g], 1'b1);
        cnt  = eerr ? 0 : 2 * (LAT + 1);
        mv[g] = 1'b0;
      end
    end
    idle_in();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_out_of_range();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
